key_stream: RTL and testbench

Read-side companion to the key register. Once the key is locked (kset high), the block snapshots the stored key bytes and the key count. It then applies them cyclically, byte by byte, to an incoming data stream (out = data XOR key byte), producing the encrypted/decrypted stream for the downstream datapath. Both sides of the stream use a valid/ready handshake with a single-entry output register.

---
 rtl/key_stream.sv | 143 ++++++++++++++
 tb/tb_key_stream.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_stream.sv
// key_stream: applies a locked key snapshot cyclically to a byte stream.
// valid/ready on both sides, single-entry registered output.
module key_stream #(
    parameter int KEY_BYTES = 4,
    parameter int DW        = 8
) (
    input  logic                                 dclk,
    input  logic                                 reset,
    input  logic                                 kset,
    input  logic [KEY_BYTES*DW-1:0]              keys,
    input  logic [$clog2(KEY_BYTES+1)-1:0]       num_keys,
    input  logic [DW-1:0]                        in_data,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    output logic [DW-1:0]                        out_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [(KEY_BYTES>1 ? $clog2(KEY_BYTES) : 1)-1:0] key_idx,
    output logic                                 busy,
    output logic                                 err
);

    localparam int NKW = $clog2(KEY_BYTES + 1);
    localparam int IW  = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam logic [NKW-1:0] MAX_NK = NKW'(KEY_BYTES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_ERR
    } state_t;

    state_t                         state_q, state_d;
    logic                           kset_q, kset_d;
    logic [KEY_BYTES-1:0][DW-1:0]   key_snap_q, key_snap_d;
    logic [NKW-1:0]                 nk_q, nk_d;
    logic [IW-1:0]                  key_idx_q, key_idx_d;
    logic [DW-1:0]                  out_data_q, out_data_d;
    logic                           out_valid_q, out_valid_d;
    logic                           err_q, err_d;
    logic                           in_ready_c;
    logic                           lock;
    logic                           legal;
    logic                           last_idx;

    assign lock     = kset & ~kset_q;
    assign legal    = (num_keys != '0) && (num_keys <= MAX_NK);
    assign last_idx = (NKW'(key_idx_q) == (nk_q - NKW'(1)));

    // next-state, datapath and handshake decode
    always_comb begin
        state_d     = state_q;
        kset_d      = kset;
        key_snap_d  = key_snap_q;
        nk_d        = nk_q;
        key_idx_d   = key_idx_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        err_d       = err_q;
        in_ready_c  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (lock) begin
                    if (legal) begin
                        key_snap_d = keys;
                        nk_d       = num_keys;
                        key_idx_d  = '0;
                        state_d    = S_RUN;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end
                end
            end
            S_RUN: begin
                if (!kset) begin
                    // unlock: stop accepting now, let the held byte drain
                    state_d = S_DRAIN;
                    if (out_valid_q && out_ready) begin
                        out_valid_d = 1'b0;
                    end
                end else begin
                    in_ready_c = ~out_valid_q | out_ready;
                    if (in_valid && in_ready_c) begin
                        out_data_d  = in_data ^ key_snap_q[key_idx_q];
                        out_valid_d = 1'b1;
                        key_idx_d   = last_idx ? '0 : key_idx_q + IW'(1);
                    end else if (out_valid_q && out_ready) begin
                        out_valid_d = 1'b0;
                    end
                end
            end
            S_DRAIN: begin
                if (!out_valid_q || out_ready) begin
                    out_valid_d = 1'b0;
                    key_idx_d   = '0;
                    state_d     = S_IDLE;
                end
            end
            S_ERR: begin
                if (!kset) begin
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // state and datapath registers
    always_ff @(posedge dclk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            kset_q      <= 1'b0;
            key_snap_q  <= '0;
            nk_q        <= '0;
            key_idx_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            kset_q      <= kset_d;
            key_snap_q  <= key_snap_d;
            nk_q        <= nk_d;
            key_idx_q   <= key_idx_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    assign in_ready  = in_ready_c;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign key_idx   = key_idx_q;
    assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign err       = err_q;

endmodule

// File: tb/tb_key_stream.sv
// tb_key_stream: table vectors, directed corner sequences and
// randomized traffic against a queue-free byte-stream reference model.
module tb_key_stream;

    logic        dclk;
    logic        reset;
    logic        kset;
    logic [31:0] keys;
    logic [2:0]  num_keys;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  key_idx;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;

    // reference model: locked key bytes, stream position, held output
    logic [7:0] m_kb [4];
    int         m_nk;
    int         m_pos;
    bit         m_have;
    logic [7:0] m_data;

    typedef struct {
        bit         iv;
        logic [7:0] id;
        bit         ordy;
        bit         e_rdy;
        logic [1:0] e_kidx;
        bit         e_ov;
        logic [7:0] e_od;
    } vec_t;

    vec_t tbl [7];

    key_stream dut (
        .dclk      (dclk),
        .reset     (reset),
        .kset      (kset),
        .keys      (keys),
        .num_keys  (num_keys),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .key_idx   (key_idx),
        .busy      (busy),
        .err       (err)
    );

    initial dclk = 1'b0;
    always #5 dclk = ~dclk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h @%0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge dclk);
        @(negedge dclk);
    endtask

    task automatic lock(input logic [31:0] k, input logic [2:0] n);
        keys     = k;
        num_keys = n;
        kset     = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        chk("lock_busy", busy, 1'b1);
        chk("lock_kidx", key_idx, 2'd0);
        chk("lock_err", err, 1'b0);
        for (int i = 0; i < 4; i++) m_kb[i] = k[8*i +: 8];
        m_nk   = n;
        m_pos  = 0;
        m_have = 1'b0;
    endtask

    task automatic unlock();
        kset      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        step();
        chk("unlock_busy", busy, 1'b0);
        chk("unlock_kidx", key_idx, 2'd0);
        chk("unlock_ov", out_valid, 1'b0);
        m_have = 1'b0;
    endtask

    // one locked cycle checked against the model
    task automatic cyc(input bit iv, input logic [7:0] d, input bit ordy);
        bit e_rdy;
        bit acc;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        e_rdy = !m_have || ordy;
        #1;
        chk("cyc_in_ready", in_ready, e_rdy);
        chk("cyc_key_idx", key_idx, 32'(m_pos % m_nk));
        acc = iv && e_rdy;
        if (acc) begin
            m_data = d ^ m_kb[m_pos % m_nk];
            m_pos++;
            m_have = 1'b1;
        end else if (m_have && ordy) begin
            m_have = 1'b0;
        end
        step();
        chk("cyc_out_valid", out_valid, m_have);
        if (m_have) chk("cyc_out_data", out_data, m_data);
    endtask

    initial begin
        tbl[0] = '{1'b1, 8'h00, 1'b1, 1'b1, 2'd0, 1'b1, 8'h11};
        tbl[1] = '{1'b1, 8'h00, 1'b1, 1'b1, 2'd1, 1'b1, 8'h22};
        tbl[2] = '{1'b1, 8'h00, 1'b1, 1'b1, 2'd2, 1'b1, 8'h33};
        tbl[3] = '{1'b1, 8'h00, 1'b1, 1'b1, 2'd3, 1'b1, 8'h44};
        tbl[4] = '{1'b1, 8'h00, 1'b1, 1'b1, 2'd0, 1'b1, 8'h11};
        tbl[5] = '{1'b1, 8'h00, 1'b1, 1'b1, 2'd1, 1'b1, 8'h22};
        tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 2'd2, 1'b0, 8'h00};

        reset     = 1'b0;
        kset      = 1'b0;
        keys      = '0;
        num_keys  = '0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        m_nk      = 1;
        m_pos     = 0;
        m_have    = 1'b0;
        m_data    = '0;
        step();
        step();
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_key_idx", key_idx, 2'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err, 1'b0);
        reset = 1'b1;
        step();
        chk("idle_in_ready", in_ready, 1'b0);

        // 4-key cyclic stream from table
        lock(32'h44332211, 3'd4);
        for (int i = 0; i < 7; i++) begin
            in_valid  = tbl[i].iv;
            in_data   = tbl[i].id;
            out_ready = tbl[i].ordy;
            #1;
            chk("tbl_in_ready", in_ready, tbl[i].e_rdy);
            chk("tbl_key_idx", key_idx, tbl[i].e_kidx);
            step();
            chk("tbl_out_valid", out_valid, tbl[i].e_ov);
            if (tbl[i].e_ov) chk("tbl_out_data", out_data, tbl[i].e_od);
        end
        unlock();

        // single key: index never moves
        lock(32'h000000A5, 3'd1);
        cyc(1'b1, 8'hFF, 1'b1);
        chk("nk1_data0", out_data, 8'h5A);
        cyc(1'b1, 8'h5A, 1'b1);
        chk("nk1_data1", out_data, 8'hFF);
        chk("nk1_kidx", key_idx, 2'd0);
        unlock();

        // backpressure, simultaneous pop/accept, key change ignored
        lock(32'h0000BBAA, 3'd2);
        cyc(1'b1, 8'h10, 1'b1);
        cyc(1'b1, 8'h20, 1'b0);
        cyc(1'b1, 8'h20, 1'b0);
        chk("bp_held", out_data, 8'h10 ^ 8'hAA);
        cyc(1'b1, 8'h20, 1'b1);
        chk("bp_pop_acc", out_data, 8'h20 ^ 8'hBB);
        keys     = 32'hFFFFFFFF;
        num_keys = 3'd3;
        cyc(1'b1, 8'h30, 1'b1);
        chk("snap_data", out_data, 8'h30 ^ 8'hAA);
        cyc(1'b1, 8'h40, 1'b1);
        cyc(1'b1, 8'h50, 1'b1);

        // drain with a held byte
        cyc(1'b1, 8'h77, 1'b1);
        kset      = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h99;
        out_ready = 1'b0;
        #1;
        chk("drn_rdy_now", in_ready, 1'b0);
        step();
        chk("drn_busy", busy, 1'b1);
        chk("drn_ov", out_valid, 1'b1);
        chk("drn_od", out_data, m_data);
        chk("drn_rdy", in_ready, 1'b0);
        step();
        chk("drn_ov_hold", out_valid, 1'b1);
        chk("drn_od_hold", out_data, m_data);
        out_ready = 1'b1;
        #1;
        chk("drn_rdy_pop", in_ready, 1'b0);
        step();
        chk("drn_ov_clr", out_valid, 1'b0);
        in_valid = 1'b0;
        step();
        chk("drn_idle_busy", busy, 1'b0);
        chk("drn_idle_kidx", key_idx, 2'd0);
        m_have = 1'b0;
        step();

        // illegal key counts
        for (int n = 0; n < 2; n++) begin
            num_keys = (n == 0) ? 3'd0 : 3'd5;
            kset     = 1'b1;
            step();
            chk("err_set", err, 1'b1);
            chk("err_rdy", in_ready, 1'b0);
            chk("err_busy", busy, 1'b0);
            step();
            chk("err_hold", err, 1'b1);
            kset = 1'b0;
            step();
            chk("err_clr", err, 1'b0);
            chk("err_idle_busy", busy, 1'b0);
            step();
        end

        // randomized rounds
        for (int r = 0; r < 3; r++) begin
            lock($urandom, 3'($urandom_range(1, 4)));
            for (int c = 0; c < 150; c++) begin
                cyc($urandom_range(0, 3) != 0,
                    8'($urandom_range(0, 255)),
                    1'($urandom_range(0, 1)));
            end
            unlock();
        end

        // async reset with a pending byte
        lock(32'h11223344, 3'd3);
        cyc(1'b1, 8'h01, 1'b0);
        cyc(1'b1, 8'h02, 1'b0);
        reset = 1'b0;
        #1;
        chk("arst_ov", out_valid, 1'b0);
        chk("arst_od", out_data, 8'h00);
        chk("arst_rdy", in_ready, 1'b0);
        chk("arst_kidx", key_idx, 2'd0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_err", err, 1'b0);
        kset     = 1'b0;
        in_valid = 1'b0;
        step();
        reset = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
